fc_psum_acc: RTL

Downstream neighbour of the FC input address generator: accumulates the PE-array partial sums produced while the input vector is streamed piece-by-piece from the IOB. Per output piece it sums i_Input_PieceNum PE beats, merges the previous tiling's partial from the output buffer (OB) when not the first tiling, and writes back either a raw partial or the final requantized, optionally ReLU'd result on the last tiling. Sits between the PE array and the OB write port.

---
 rtl/fc_psum_acc_if.sv | 37 +++
 rtl/fc_psum_acc.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fc_psum_acc_if.sv
//==============================================================================
// Module      : fc_psum_acc_if
// Description : PE psum stream and output-buffer read/write port bundle
//               for the FC partial-sum accumulator.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fc_psum_acc_if #(
  parameter int LANES  = 4,
  parameter int DW_IN  = 16,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 12
);
  logic                     i_PE_Valid;
  logic [LANES*DW_IN-1:0]   i_PE_Psum;
  logic                     o_PE_Ready;
  logic                     o_OB_REn;
  logic [ADDR_W-1:0]        o_OB_RAddr;
  logic [LANES*ACC_W-1:0]   i_OB_RData;
  logic                     o_OB_WEn;
  logic [ADDR_W-1:0]        o_OB_WAddr;
  logic [LANES*ACC_W-1:0]   o_OB_WData;

  // slave: accumulator side; master: PE array / output buffer side
  modport slave (
    input  i_PE_Valid, i_PE_Psum, i_OB_RData,
    output o_PE_Ready, o_OB_REn, o_OB_RAddr, o_OB_WEn, o_OB_WAddr, o_OB_WData
  );
  modport master (
    output i_PE_Valid, i_PE_Psum, i_OB_RData,
    input  o_PE_Ready, o_OB_REn, o_OB_RAddr, o_OB_WEn, o_OB_WAddr, o_OB_WData
  );
endinterface

`default_nettype wire

// File: rtl/fc_psum_acc.sv
//==============================================================================
// Module      : fc_psum_acc
// Description : Accumulates PE partial sums per output piece, merges the OB
//               partial on later tilings, writes raw or requantized results.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fc_psum_acc #(
  parameter int LANES  = 4,
  parameter int DW_IN  = 16,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 12
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  input  wire logic              i_AccStart,
  input  wire logic [ADDR_W-1:0] i_StartAdder,
  input  wire logic [7:0]        i_Input_PieceNum,
  input  wire logic [7:0]        i_Out_PieceNum,
  input  wire logic              i_bFirstTiling,
  input  wire logic              i_bLastTiling,
  input  wire logic [4:0]        i_Shift,
  input  wire logic              i_bRelu,
  fc_psum_acc_if.slave           bus,
  output logic                   o_AccDone
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_MRD   = 3'd2,
    S_MWAIT = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic signed [ACC_W:0] c_satMax = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] c_satMin = -c_satMax - 1;

  state_t                        r_state;
  state_t                        w_nextState;
  logic [ADDR_W-1:0]             r_base;
  logic [7:0]                    r_inNum;
  logic [7:0]                    r_outNum;
  logic                          r_first;
  logic                          r_last;
  logic [4:0]                    r_shift;
  logic                          r_relu;
  logic [7:0]                    r_inCnt;
  logic [7:0]                    r_outCnt;
  logic [LANES-1:0][ACC_W-1:0]   r_acc;
  logic                          w_lastBeat;
  logic                          w_lastPiece;
  logic                          w_cfgZero;
  logic                          w_beat;
  logic [ADDR_W-1:0]             w_addr;
  logic [LANES*ACC_W-1:0]        w_wdata;

  assign w_lastBeat  = ({1'b0, r_inCnt} + 9'd1) == {1'b0, r_inNum};
  assign w_lastPiece = ({1'b0, r_outCnt} + 9'd1) == {1'b0, r_outNum};
  assign w_cfgZero   = (i_Input_PieceNum == 8'd0) || (i_Out_PieceNum == 8'd0);
  assign w_beat      = (r_state == S_ACC) && bus.i_PE_Valid;
  assign w_addr      = r_base + ADDR_W'(r_outCnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  w_nextState = S_IDLE;
      S_ACC:   if (w_beat && w_lastBeat) w_nextState = r_first ? S_WR : S_MRD;
      S_MRD:   w_nextState = S_MWAIT;
      S_MWAIT: w_nextState = S_WR;
      S_WR:    w_nextState = w_lastPiece ? S_DONE : S_ACC;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
    // A start in any state (re)launches a pass; an empty pass finishes at once
    if (i_AccStart) w_nextState = w_cfgZero ? S_DONE : S_ACC;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base   <= '0;
      r_inNum  <= '0;
      r_outNum <= '0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_shift  <= '0;
      r_relu   <= 1'b0;
      r_inCnt  <= '0;
      r_outCnt <= '0;
      r_acc    <= '0;
    end else if (i_AccStart) begin
      r_base   <= i_StartAdder;
      r_inNum  <= i_Input_PieceNum;
      r_outNum <= i_Out_PieceNum;
      r_first  <= i_bFirstTiling;
      r_last   <= i_bLastTiling;
      r_shift  <= i_Shift;
      r_relu   <= i_bRelu;
      r_inCnt  <= '0;
      r_outCnt <= '0;
    end else begin
      if (w_beat) begin
        r_inCnt <= w_lastBeat ? 8'd0 : r_inCnt + 8'd1;
        for (int i = 0; i < LANES; i++) begin
          r_acc[i] <= ((r_inCnt == 8'd0) ? '0 : r_acc[i]) +
                      {{(ACC_W-DW_IN){bus.i_PE_Psum[i*DW_IN+DW_IN-1]}},
                       bus.i_PE_Psum[i*DW_IN +: DW_IN]};
        end
      end
      if (r_state == S_MWAIT) begin
        for (int i = 0; i < LANES; i++) begin
          r_acc[i] <= r_acc[i] + bus.i_OB_RData[i*ACC_W +: ACC_W];
        end
      end
      if (r_state == S_WR && !w_lastPiece) r_outCnt <= r_outCnt + 8'd1;
    end
  end

  // Per-lane round-half-up shift, optional ReLU, saturation to OUT_W
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [ACC_W:0]   w_rnd;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W:0]   w_shr;
    logic signed [OUT_W-1:0] w_sat;

    always_comb begin
      w_rnd = '0;
      if (r_shift != 5'd0) w_rnd = {{ACC_W{1'b0}}, 1'b1} << (r_shift - 5'd1);
      w_sum = $signed({r_acc[g][ACC_W-1], r_acc[g]}) + w_rnd;
      w_shr = w_sum >>> r_shift;
      if (r_relu && w_shr[ACC_W]) w_shr = '0;
      if (w_shr > c_satMax)      w_sat = c_satMax[OUT_W-1:0];
      else if (w_shr < c_satMin) w_sat = c_satMin[OUT_W-1:0];
      else                       w_sat = w_shr[OUT_W-1:0];
    end

    assign w_wdata[g*ACC_W +: ACC_W] = r_last ?
        {{(ACC_W-OUT_W){w_sat[OUT_W-1]}}, w_sat} : r_acc[g];
  end

  assign bus.o_PE_Ready = (r_state == S_ACC);
  assign bus.o_OB_REn   = (r_state == S_MRD);
  assign bus.o_OB_RAddr = (r_state == S_MRD) ? w_addr : '0;
  assign bus.o_OB_WEn   = (r_state == S_WR);
  assign bus.o_OB_WAddr = (r_state == S_WR) ? w_addr : '0;
  assign bus.o_OB_WData = (r_state == S_WR) ? w_wdata : '0;
  assign o_AccDone      = (r_state == S_DONE);

endmodule

`default_nettype wire
